// File: rtl/mmcm_reconfig_ctrl.sv
// MMCM reconfiguration controller.
// Accepts bank-switch requests into a single pending slot, hands the
// selected bank to a DRP write stage, then waits for the MMCM to relock
// and stay locked for a settle window before reporting completion.
// A watchdog aborts the operation if relock never settles.
module mmcm_reconfig_ctrl #(
    parameter int RSEL_WIDTH     = 1,
    parameter int ADDR_WIDTH     = 5,
    parameter int CONFIG_COUNT   = 23,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [RSEL_WIDTH-1:0] req_sel,
    output logic                  req_ready,
    output logic [RSEL_WIDTH-1:0] s_baddr,
    output logic [ADDR_WIDTH-1:0] s_count,
    output logic                  s_valid,
    input  logic                  s_ready,
    input  logic                  locked,
    output logic [RSEL_WIDTH-1:0] cur_sel,
    output logic                  cur_valid,
    output logic                  busy,
    output logic                  clk_gate_en,
    output logic                  done,
    output logic                  err,
    output logic                  err_sticky
);

    localparam int SETTLE_W  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
    localparam int TIMEOUT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_LOCK,
        SETTLE
    } state_t;

    state_t state, next_state;

    logic                  locked_meta;
    logic                  locked_s;
    logic                  pend_valid;
    logic [RSEL_WIDTH-1:0] pend_sel;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [TIMEOUT_W-1:0]  timeout_cnt;

    // Decoded one-cycle events from the FSM
    logic take_skip;     // pending bank already applied: just acknowledge
    logic take_issue;    // pending bank goes out to the DRP stage
    logic handshake;     // DRP stage accepted the command
    logic waiting;       // watchdog is running
    logic timeout_hit;   // watchdog expired this cycle
    logic settle_clear;  // lock seen with DRP idle: start the settle window
    logic settle_done;   // settle window complete and no timeout

    // The DRP stage is reset by the same signal, so acceptance only depends on reset
    assign req_ready = ~reset;
    // The DRP stage performs s_count+1 writes
    assign s_count   = ADDR_WIDTH'(CONFIG_COUNT - 1);

    // Two-flop synchroniser for the asynchronous lock indicator
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // FSM next-state and event decode; timeout outranks settle completion
    always_comb begin
        // NOTE: every output of this block is given a default first so that
        // no path through the case statement can infer a latch.
        next_state   = state;
        take_skip    = 1'b0;
        take_issue   = 1'b0;
        handshake    = 1'b0;
        waiting      = 1'b0;
        timeout_hit  = 1'b0;
        settle_clear = 1'b0;
        settle_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_valid) begin
                    if (cur_valid && (pend_sel == cur_sel)) begin
                        take_skip = 1'b1;
                    end else begin
                        take_issue = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (s_ready) begin
                    handshake  = 1'b1;
                    next_state = WAIT_START;
                end
            end
            WAIT_START, WAIT_LOCK, SETTLE: begin
                waiting = 1'b1;
                if (timeout_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = IDLE;
                end else if (state == WAIT_START) begin
                    if (!s_ready) next_state = WAIT_LOCK;
                end else if (state == WAIT_LOCK) begin
                    if (s_ready && locked_s) begin
                        settle_clear = 1'b1;
                        next_state   = SETTLE;
                    end
                end else if (!locked_s) begin
                    next_state = WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    settle_done = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Directly decoded outputs
    assign s_valid = (state == ISSUE);
    assign busy    = (state != IDLE);
    assign err     = timeout_hit;

    // Pending slot: a new request always wins over consumption
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_sel   <= '0;
        end else if (req_valid) begin
            pend_valid <= 1'b1;
            pend_sel   <= req_sel;
        end else if (take_skip || take_issue) begin
            pend_valid <= 1'b0;
        end
    end

    // Saturating watchdog and settle counters
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= '0;
            settle_cnt  <= '0;
        end else begin
            if (handshake) begin
                timeout_cnt <= '0;
            end else if (waiting && (timeout_cnt != TIMEOUT_LAST)) begin
                timeout_cnt <= timeout_cnt + 1'b1;
            end
            if (settle_clear) begin
                settle_cnt <= '0;
            end else if ((state == SETTLE) && locked_s && (settle_cnt != SETTLE_LAST)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Applied-bank status, completion/error flags and clock gating
    always_ff @(posedge clk) begin
        if (reset) begin
            s_baddr     <= '0;
            cur_sel     <= '0;
            cur_valid   <= 1'b0;
            done        <= 1'b0;
            err_sticky  <= 1'b0;
            clk_gate_en <= 1'b0;
        end else begin
            done <= take_skip || settle_done;
            if (take_issue) begin
                s_baddr    <= pend_sel;
                err_sticky <= 1'b0;
            end
            if (settle_done) begin
                cur_sel   <= s_baddr;
                cur_valid <= 1'b1;
            end
            if (timeout_hit) begin
                err_sticky <= 1'b1;
                cur_valid  <= 1'b0;
            end
            // Gate closes on issue or abort; while idle it follows cur_valid,
            // which keeps it low through the completion cycle itself
            if (take_issue || timeout_hit) begin
                clk_gate_en <= 1'b0;
            end else if (state == IDLE) begin
                clk_gate_en <= cur_valid;
            end
        end
    end

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Self-checking bench for mmcm_reconfig_ctrl. The bench plays the DRP stage
// and the MMCM lock output; expected timings are computed arithmetically
// from the controller's rules (lock sampling edge + settle window, handshake
// edge + watchdog length) and the applied bank is tracked in a small model.
module tb_mmcm_reconfig_ctrl;

    localparam int RSEL_WIDTH     = 1;
    localparam int ADDR_WIDTH     = 5;
    localparam int CONFIG_COUNT   = 23;
    localparam int SETTLE_CYCLES  = 64;
    localparam int TIMEOUT_CYCLES = 600;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  req_valid = 1'b0;
    logic [RSEL_WIDTH-1:0] req_sel = '0;
    logic                  req_ready;
    logic [RSEL_WIDTH-1:0] s_baddr;
    logic [ADDR_WIDTH-1:0] s_count;
    logic                  s_valid;
    logic                  s_ready = 1'b1;
    logic                  locked = 1'b0;
    logic [RSEL_WIDTH-1:0] cur_sel;
    logic                  cur_valid;
    logic                  busy;
    logic                  clk_gate_en;
    logic                  done;
    logic                  err;
    logic                  err_sticky;

    mmcm_reconfig_ctrl #(
        .RSEL_WIDTH    (RSEL_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CONFIG_COUNT  (CONFIG_COUNT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .s_baddr    (s_baddr),
        .s_count    (s_count),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .locked     (locked),
        .cur_sel    (cur_sel),
        .cur_valid  (cur_valid),
        .busy       (busy),
        .clk_gate_en(clk_gate_en),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Posedge counter: at a negedge, cyc is the index of the edge just taken
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event counters observed mid-cycle
    int hs_count   = 0;
    int done_count = 0;
    int err_count  = 0;
    always @(negedge clk) begin
        if (s_valid && s_ready && !reset) hs_count <= hs_count + 1;
        if (done) done_count <= done_count + 1;
        if (err)  err_count  <= err_count + 1;
    end

    // Reference model of the applied bank
    logic [RSEL_WIDTH-1:0] exp_cur_sel   = '0;
    logic                  exp_cur_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle request pulse, sampled by the next posedge
    task automatic request(input logic [RSEL_WIDTH-1:0] sel);
        req_valid = 1'b1;
        req_sel   = sel;
        tick(1);
        req_valid = 1'b0;
    endtask

    // Wait for s_valid; returns the edge index of the handshake or -1
    task automatic wait_issue(output int hs_e);
        hs_e = -1;
        for (int i = 0; i < 8; i++) begin
            if (s_valid && s_ready) begin
                hs_e = cyc + 1;
                return;
            end
            tick(1);
        end
    endtask

    // Wait for done (want_err=0) or err (want_err=1); returns cycle or -1
    task automatic wait_pulse(input bit want_err, input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            if (want_err ? err : done) begin
                at = cyc;
                return;
            end
            tick(1);
        end
    endtask

    // DRP stage and MMCM behaviour after an accepted command. Returns the
    // edge that samples the final rising edge of locked.
    task automatic drp_run(input int n_low, input int lock_delay, input int glitch,
                           input bit late_req, output int lock_e);
        tick(1);
        s_ready = 1'b0;
        locked  = 1'b0;
        if (late_req) begin
            request('0);
            request('1);
            tick(n_low - 2);
        end else begin
            tick(n_low);
        end
        s_ready = 1'b1;
        tick(lock_delay);
        locked = 1'b1;
        lock_e = cyc + 1;
        if (glitch > 0) begin
            tick(glitch);
            locked = 1'b0;
            tick(3);
            locked = 1'b1;
            lock_e = cyc + 1;
        end
    endtask

    // Full reconfiguration expected to target bank sel
    task automatic run_op(input string tag, input logic [RSEL_WIDTH-1:0] sel, input int n_low,
                          input int lock_delay, input int glitch, input bit late_req);
        int hs_e;
        int lock_e;
        int at;
        wait_issue(hs_e);
        if (hs_e < 0) begin
            check({tag, " issue"}, 32'(s_valid), 1);
            return;
        end
        check({tag, " s_baddr"}, 32'(s_baddr), 32'(sel));
        check({tag, " gate off in issue"}, 32'(clk_gate_en), 0);
        check({tag, " err_sticky cleared"}, 32'(err_sticky), 0);
        check({tag, " busy"}, 32'(busy), 1);
        drp_run(n_low, lock_delay, glitch, late_req, lock_e);
        wait_pulse(1'b0, 400, at);
        check({tag, " done cycle"}, at, lock_e + SETTLE_CYCLES + 2);
        check({tag, " cur_sel"}, 32'(cur_sel), 32'(sel));
        check({tag, " cur_valid"}, 32'(cur_valid), 1);
        check({tag, " gate off at done"}, 32'(clk_gate_en), 0);
        exp_cur_sel   = sel;
        exp_cur_valid = 1'b1;
    endtask

    int hs0, d0, e0, at, hs_e;
    logic [RSEL_WIDTH-1:0] sel;

    initial begin
        // Reset state
        tick(3);
        check("reset req_ready", 32'(req_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset s_valid", 32'(s_valid), 0);
        check("reset cur_valid", 32'(cur_valid), 0);
        check("reset gate", 32'(clk_gate_en), 0);
        check("reset err_sticky", 32'(err_sticky), 0);
        reset = 1'b0;
        tick(1);
        check("req_ready", 32'(req_ready), 1);
        check("s_count", 32'(s_count), CONFIG_COUNT - 1);
        check("idle done", 32'(done), 0);

        // Basic reconfiguration to bank 1
        request(1'b1);
        run_op("basic", 1'b1, 30, 0, 0, 1'b0);
        tick(1);
        check("basic done width", 32'(done), 0);
        check("basic gate on", 32'(clk_gate_en), 1);
        check("basic busy", 32'(busy), 0);

        // Skip: bank already applied
        hs0 = hs_count;
        request(1'b1);
        check("skip no issue", 32'(s_valid), 0);
        tick(1);
        check("skip done", 32'(done), 1);
        check("skip gate", 32'(clk_gate_en), 1);
        tick(1);
        check("skip gate after", 32'(clk_gate_en), 1);
        check("skip busy", 32'(busy), 0);
        tick(2);
        check("skip handshakes", hs_count, hs0);

        // Latest wins: requests 0 then 1 while busy on bank 0
        hs0 = hs_count;
        request(1'b0);
        run_op("lw first", 1'b0, 30, 2, 0, 1'b1);
        run_op("lw second", 1'b1, 10, 0, 0, 1'b0);
        tick(20);
        check("lw handshakes", hs_count, hs0 + 2);
        check("lw idle", 32'(busy), 0);

        // Lock glitch during settle restarts the window
        request(1'b0);
        run_op("glitch", 1'b0, 12, 3, 20, 1'b0);
        tick(1);
        check("glitch gate on", 32'(clk_gate_en), 1);

        // Randomised operations against the model
        for (int it = 0; it < 8; it++) begin
            sel = RSEL_WIDTH'($urandom_range(0, 1));
            if (exp_cur_valid && sel == exp_cur_sel) begin
                request(sel);
                tick(1);
                check("rand skip done", 32'(done), 1);
                check("rand skip no issue", 32'(s_valid), 0);
            end else begin
                request(sel);
                run_op("rand op", sel, $urandom_range(3, 40), $urandom_range(0, 10),
                       ($urandom_range(0, 1) == 1) ? $urandom_range(3, SETTLE_CYCLES - 6) : 0,
                       1'b0);
            end
            tick(1);
            check("rand gate on", 32'(clk_gate_en), 1);
            check("rand cur_sel", 32'(cur_sel), 32'(exp_cur_sel));
            tick(2);
        end

        // Timeout: lock never returns
        d0 = done_count;
        sel = ~exp_cur_sel;
        request(sel);
        wait_issue(hs_e);
        if (hs_e < 0) begin
            check("to issue", 32'(s_valid), 1);
        end else begin
            tick(1);
            s_ready = 1'b0;
            locked  = 1'b0;
            tick(3);
            s_ready = 1'b1;
            wait_pulse(1'b1, TIMEOUT_CYCLES + 50, at);
            check("to err cycle", at, hs_e + TIMEOUT_CYCLES - 1);
            tick(1);
            check("to err width", 32'(err), 0);
            check("to err_sticky", 32'(err_sticky), 1);
            check("to cur_valid", 32'(cur_valid), 0);
            check("to gate", 32'(clk_gate_en), 0);
            check("to busy", 32'(busy), 0);
            tick(3);
            check("to gate held", 32'(clk_gate_en), 0);
            check("to no done", done_count, d0);
            exp_cur_valid = 1'b0;
        end

        // Recovery: same bank as before is issued since cur_valid is clear
        request(exp_cur_sel);
        run_op("recover", exp_cur_sel, 5, 1, 0, 1'b0);
        tick(1);
        check("recover gate on", 32'(clk_gate_en), 1);
        check("recover err_sticky", 32'(err_sticky), 0);

        // Reset during WAIT_LOCK with a request pending
        request(~exp_cur_sel);
        wait_issue(hs_e);
        check("rst issue", 32'(s_valid), 1);
        tick(1);
        s_ready = 1'b0;
        locked  = 1'b0;
        tick(4);
        s_ready = 1'b1;
        tick(3);
        request(exp_cur_sel);
        tick(1);
        hs0 = hs_count;
        d0  = done_count;
        e0  = err_count;
        reset = 1'b1;
        tick(1);
        check("rst busy", 32'(busy), 0);
        check("rst s_valid", 32'(s_valid), 0);
        check("rst s_baddr", 32'(s_baddr), 0);
        check("rst cur_sel", 32'(cur_sel), 0);
        check("rst cur_valid", 32'(cur_valid), 0);
        check("rst gate", 32'(clk_gate_en), 0);
        check("rst done", 32'(done), 0);
        check("rst err", 32'(err), 0);
        check("rst err_sticky", 32'(err_sticky), 0);
        check("rst req_ready", 32'(req_ready), 0);
        reset = 1'b0;
        tick(10);
        check("rst pending discarded", 32'(busy), 0);
        check("rst no handshake", hs_count, hs0);
        check("rst no done", done_count, d0);
        check("rst no err", err_count, e0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmcm_reconfig_ctrl.md
MMCM_RECONFIG_CTRL -- requirements
Module: mmcm_reconfig_ctrl

Interface
REQ-001 SHALL have parameter RSEL_WIDTH, default 1: width of the configuration-bank select.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: width of the DRP-stage write count.
REQ-003 SHALL have parameter CONFIG_COUNT, default 23: number of DRP writes per bank.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 64: number of cycles locked must stay stable before done.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 65536: number of cycles from issue to completion before an error is raised.
REQ-006 SHALL have the following ports, listed as name, direction, width, meaning:
  clk  in  1  clock.
  reset  in  1  synchronous, active-high reset.
  req_valid  in  1  user reconfiguration request.
  req_sel  in  RSEL_WIDTH  requested bank.
  req_ready  out  1  request accepted into the pending slot.
  s_baddr  out  RSEL_WIDTH  bank sent to the DRP stage.
  s_count  out  ADDR_WIDTH  write count sent to the DRP stage.
  s_valid  out  1  command valid to the DRP stage.
  s_ready  in  1  DRP stage idle and accepting.
  locked  in  1  MMCM locked; asynchronous.
  cur_sel  out  RSEL_WIDTH  bank currently applied.
  cur_valid  out  1  cur_sel is meaningful.
  busy  out  1  reconfiguration in progress.
  clk_gate_en  out  1  downstream clocks enabled.
  done  out  1  one-cycle completion pulse.
  err  out  1  one-cycle timeout pulse.
  err_sticky  out  1  timeout occurred since the last accepted request.

Function
REQ-007 SHALL synchronise locked through a 2-flop chain to locked_s; all logic SHALL use locked_s only.
REQ-008 SHALL hold a single pending slot {pend_valid, pend_sel}; req_ready SHALL be 1 whenever not in reset.
REQ-009 On req_valid, SHALL set pend_valid and load pend_sel; a newer request SHALL overwrite an unconsumed one (latest wins).
REQ-010 SHALL keep s_count constant at CONFIG_COUNT-1, because the DRP stage performs s_count+1 writes.
REQ-011 SHALL implement the FSM states IDLE, ISSUE, WAIT_START, WAIT_LOCK, SETTLE.
REQ-012 In IDLE with pend_valid: if cur_valid and pend_sel==cur_sel, SHALL clear pend_valid, pulse done the next cycle, and stay in IDLE (skip); otherwise SHALL go to ISSUE, copy pend_sel into s_baddr, clear pend_valid, and clear err_sticky.
REQ-013 In ISSUE: s_valid=1, held until s_ready; the handshake cycle SHALL start the timeout counter at 0 and move to WAIT_START.
REQ-014 In WAIT_START: SHALL wait for s_ready==0 (DRP stage busy), then move to WAIT_LOCK.
REQ-015 In WAIT_LOCK: when s_ready==1 and locked_s==1, SHALL clear the settle counter and move to SETTLE.
REQ-016 In SETTLE: the settle counter SHALL increment while locked_s==1; on locked_s==0 it SHALL return to WAIT_LOCK; on reaching SETTLE_CYCLES-1, the next state SHALL be IDLE, with cur_sel=s_baddr, cur_valid=1, and done pulsed one cycle.
REQ-017 In WAIT_START, WAIT_LOCK and SETTLE, the timeout counter SHALL increment; on reaching TIMEOUT_CYCLES-1, SHALL pulse err, set err_sticky, set cur_valid=0, and go to IDLE.
REQ-018 If timeout and settle completion occur in the same cycle, timeout SHALL win.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 clk_gate_en SHALL be 0 from the ISSUE entry cycle until the done cycle inclusive, and 0 after a timeout; it SHALL be 1 otherwise, once cur_valid==1.
REQ-021 Counters SHALL be sized $clog2 of their limit and SHALL saturate; they SHALL never wrap.
REQ-022 Requests arriving while busy SHALL only update the pending slot and SHALL be serviced on return to IDLE.
REQ-023 s_valid SHALL never deassert before its handshake completes.

Reset
REQ-024 While reset is asserted: FSM=IDLE; pend_valid=0; s_valid=0; s_baddr=0; cur_sel=0; cur_valid=0; busy=0; clk_gate_en=0; done=0; err=0; err_sticky=0; counters=0; sync flops=0.
REQ-025 Reset asserted mid-operation SHALL abandon the operation and discard the pending request; the DRP stage is reset by the same signal.

Verification
REQ-026 Sequence: req_sel=1 -> s_valid handshake -> s_ready low 30 cycles -> locked high -> done exactly SETTLE_CYCLES+2 sync cycles after lock, with cur_sel=1 and cur_valid=1.
REQ-027 Skip case: with cur_sel=1 and cur_valid=1, request sel 1 -> no s_valid, done within 2 cycles, clk_gate_en stays 1.
REQ-028 Latest wins: while busy, request sel 0 then sel 1 -> exactly one further issue, with s_baddr=1.
REQ-029 Lock glitch: locked drops for 3 cycles during SETTLE -> settle restarts, and done is delayed accordingly.
REQ-030 Timeout: locked never returns -> err pulses at TIMEOUT_CYCLES-1 after the handshake, err_sticky=1, cur_valid=0, clk_gate_en=0.
REQ-031 Reset asserted in WAIT_LOCK -> all outputs at their reset values the next cycle, and no done or err pulse.
